// File: rtl/data_sram_responder.sv
// ----------------------------------------------------------------------------
// data_sram_responder
//
// Behavioural SRAM responder for a simple req/addr_ok/data_ok bus.
// Requests are accepted whenever the response queue has room. A store writes
// the selected byte lanes of the word array at the accepting edge. A load
// captures the whole addressed word at the accepting edge. Every accepted
// request, load or store, gets one queue entry. That entry becomes a single
// data_ok pulse LATENCY cycles later, or later if older entries are still
// waiting. Responses leave in acceptance order.
//
// Parameters
//   ADDR_WORDS : number of 32-bit storage words
//   LATENCY    : cycles from accept to data_ok (1..8)
//   QDEPTH     : maximum outstanding requests (power of two, 2..8)
//
// Ports
//   clk      : clock for all state
//   rst      : asynchronous, active-high reset (queue only, not storage)
//   req      : request valid
//   wr       : 1 = store, 0 = load
//   size     : access size, accepted but not interpreted
//   wstrb    : byte write enables for stores
//   addr     : byte address, word index taken from addr[IW+1:2]
//   wdata    : lane-replicated store data
//   addr_ok  : request is accepted this cycle if req=1 (queue not full)
//   data_ok  : head response valid, one cycle per accepted request
//   rdata    : load data when data_ok=1 for a load, otherwise zero
// ----------------------------------------------------------------------------
module data_sram_responder #(
    parameter int ADDR_WORDS = 1024,
    parameter int LATENCY    = 2,
    parameter int QDEPTH     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [3:0]  wstrb,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata
);

    localparam int IW  = $clog2(ADDR_WORDS);
    localparam int PW  = $clog2(QDEPTH);
    localparam int CW  = PW + 1;
    localparam int CDW = 3;

    localparam logic [CW-1:0]  FULL_COUNT = CW'(QDEPTH);
    localparam logic [PW-1:0]  PTR_ONE    = PW'(1);
    localparam logic [CW-1:0]  CNT_ONE    = CW'(1);
    localparam logic [CDW-1:0] CD_INIT    = CDW'(LATENCY - 1);

    // Word storage; deliberately not reset so data survives a queue reset.
    logic [31:0] r_mem [ADDR_WORDS];

    // Response queue entries.
    logic [31:0]                r_word [QDEPTH];
    logic [QDEPTH-1:0]          r_isStore;
    logic [QDEPTH-1:0]          r_valid;
    logic [QDEPTH-1:0][CDW-1:0] r_cd;

    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;

    logic [IW-1:0] w_idx;
    logic [31:0]   w_memWord;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_headValid;
    logic          w_headReady;
    logic          w_unusedBits;

    assign w_idx     = addr[IW+1:2];
    assign w_memWord = r_mem[w_idx];

    // Size and address bits outside the index are not interpreted.
    assign w_unusedBits = ^{size, addr[1:0], addr[31:IW+2]};

    // addr_ok depends only on occupancy. There is no bypass from a pop in the
    // same cycle, so a full queue refuses a request even while data_ok=1.
    assign w_full  = (r_count == FULL_COUNT);
    assign addr_ok = ~w_full;
    assign w_push  = req & ~w_full;

    assign w_headValid = r_valid[r_head];
    assign w_headReady = (r_cd[r_head] == '0);
    assign data_ok     = w_headValid & w_headReady;
    assign w_pop       = data_ok;

    // Store responses and idle cycles drive zero on rdata.
    assign rdata = (data_ok && !r_isStore[r_head]) ? r_word[r_head] : 32'h0;

    // Byte-lane writes land at the accepting edge. A load accepted one cycle
    // later reads the updated word.
    always_ff @(posedge clk) begin
        if (w_push && wr) begin
            for (int k = 0; k < 4; k++) begin
                if (wstrb[k]) begin
                    r_mem[w_idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // Entry payload capture. Loads take the word as it stands before this
    // edge. Stores record only their kind.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_word[r_tail]    <= wr ? 32'h0 : w_memWord;
            r_isStore[r_tail] <= wr;
        end
    end

    // Per-entry valid and countdown. A newly pushed entry starts at
    // LATENCY-1. Every live entry counts down once per cycle and stops at 0,
    // so an entry stuck behind older ones is ready as soon as it reaches the
    // head.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            r_cd    <= '0;
        end else begin
            for (int i = 0; i < QDEPTH; i++) begin
                if (w_push && (r_tail == PW'(i))) begin
                    r_valid[i] <= 1'b1;
                    r_cd[i]    <= CD_INIT;
                end else begin
                    if (w_pop && (r_head == PW'(i))) begin
                        r_valid[i] <= 1'b0;
                    end
                    if (r_valid[i] && (r_cd[i] != '0)) begin
                        r_cd[i] <= r_cd[i] - CDW'(1);
                    end
                end
            end
        end
    end

    // Circular pointers wrap naturally because QDEPTH is a power of two.
    // A push and a pop in the same cycle leave the occupancy unchanged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PTR_ONE;
            end
            if (w_pop) begin
                r_head <= r_head + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_ONE;
                2'b01:   r_count <= r_count - CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_responder.sv
// ----------------------------------------------------------------------------
// tb_data_sram_responder
//
// Directed bench for data_sram_responder. Instance dut uses the default
// parameters (LATENCY=2, QDEPTH=2). Instance dutL1 uses LATENCY=1 and runs
// a continuous request stream. Expected values are worked out by hand for
// each scenario.
// ----------------------------------------------------------------------------
module tb_data_sram_responder;

    logic        clk;
    logic        rst;

    logic        req;
    logic        wr;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addrOk;
    logic        dataOk;
    logic [31:0] rdata;

    logic        req1;
    logic        wr1;
    logic [3:0]  wstrb1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        addrOk1;
    logic        dataOk1;
    logic [31:0] rdata1;

    int assertCount = 0;
    int failCount   = 0;
    int okSeen;

    data_sram_responder dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr      (wr),
        .size    (2'b10),
        .wstrb   (wstrb),
        .addr    (addr),
        .wdata   (wdata),
        .addr_ok (addrOk),
        .data_ok (dataOk),
        .rdata   (rdata)
    );

    data_sram_responder #(.ADDR_WORDS(1024), .LATENCY(1), .QDEPTH(2)) dutL1 (
        .clk     (clk),
        .rst     (rst),
        .req     (req1),
        .wr      (wr1),
        .size    (2'b10),
        .wstrb   (wstrb1),
        .addr    (addr1),
        .wdata   (wdata1),
        .addr_ok (addrOk1),
        .data_ok (dataOk1),
        .rdata   (rdata1)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 ns after the next rising edge. Inputs are driven and
    // outputs are sampled there, well away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, wanted 0x%08h", tag, observed, expected);
        end
    endtask

    // Drive one request cycle on the default instance.
    task automatic applyStimulus(input logic r, input logic w, input logic [31:0] a,
                                 input logic [3:0] s, input logic [31:0] d);
        req   = r;
        wr    = w;
        addr  = a;
        wstrb = s;
        wdata = d;
    endtask

    // One isolated access on an empty queue: accepted at T, data_ok at T+2.
    task automatic singleAccess(input string tag, input logic w, input logic [31:0] a,
                                input logic [3:0] s, input logic [31:0] d,
                                input logic [31:0] expRdata);
        applyStimulus(1'b1, w, a, s, d);
        checkOutput({tag, ".addrOk"}, 32'(addrOk), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        checkOutput({tag, ".earlyDataOk"}, 32'(dataOk), 32'd0);
        tick();
        checkOutput({tag, ".dataOk"}, 32'(dataOk), 32'd1);
        checkOutput({tag, ".rdata"}, rdata, expRdata);
        tick();
    endtask

    // Stream table for the LATENCY=1 instance.
    logic        streamWr   [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic [31:0] streamAddr [6] = '{32'h4, 32'h8, 32'hC, 32'h4, 32'h8, 32'hC};
    logic [31:0] streamData [6] = '{32'h01010101, 32'h02020202, 32'h03030303,
                                    32'h0, 32'h0, 32'h0};
    logic [31:0] streamExp  [8] = '{32'h0, 32'h0, 32'h0, 32'h0,
                                    32'h01010101, 32'h02020202, 32'h03030303, 32'h0};

    initial begin
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        req1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wstrb1 = 4'h0; wdata1 = 32'h0;

        // Reset-state outputs.
        tick();
        tick();
        checkOutput("reset.addrOk", 32'(addrOk), 32'd1);
        checkOutput("reset.dataOk", 32'(dataOk), 32'd0);
        checkOutput("reset.rdata", rdata, 32'h0);
        rst = 1'b0;
        tick();

        // Store 0xDEADBEEF to 0x10, then load it back on the next cycle.
        applyStimulus(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
        checkOutput("raw.T.addrOk", 32'(addrOk), 32'd1);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        checkOutput("raw.T1.addrOk", 32'(addrOk), 32'd1);
        checkOutput("raw.T1.dataOk", 32'(dataOk), 32'd0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        checkOutput("raw.T2.addrOk", 32'(addrOk), 32'd0);
        checkOutput("raw.T2.dataOk", 32'(dataOk), 32'd1);
        checkOutput("raw.T2.rdata", rdata, 32'h0);
        tick();
        checkOutput("raw.T3.addrOk", 32'(addrOk), 32'd1);
        checkOutput("raw.T3.dataOk", 32'(dataOk), 32'd1);
        checkOutput("raw.T3.rdata", rdata, 32'hDEADBEEF);
        tick();
        checkOutput("raw.T4.dataOk", 32'(dataOk), 32'd0);
        checkOutput("raw.T4.rdata", rdata, 32'h0);

        // Byte-lane store into word 0x20.
        singleAccess("byte.init", 1'b1, 32'h20, 4'hF, 32'h11223344, 32'h0);
        singleAccess("byte.lane2", 1'b1, 32'h20, 4'b0100, 32'hAAAAAAAA, 32'h0);
        singleAccess("byte.load", 1'b0, 32'h20, 4'h0, 32'h0, 32'h11AA3344);

        // Two back-to-back loads fill the queue.
        applyStimulus(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        checkOutput("full.T1.addrOk", 32'(addrOk), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        checkOutput("full.T2.addrOk", 32'(addrOk), 32'd0);
        checkOutput("full.T2.dataOk", 32'(dataOk), 32'd1);
        checkOutput("full.T2.rdata", rdata, 32'hDEADBEEF);
        tick();
        checkOutput("full.T3.addrOk", 32'(addrOk), 32'd1);
        checkOutput("full.T3.dataOk", 32'(dataOk), 32'd1);
        checkOutput("full.T3.rdata", rdata, 32'h11AA3344);
        tick();
        checkOutput("full.T4.dataOk", 32'(dataOk), 32'd0);

        // A refused store must not touch storage or the queue.
        singleAccess("refuse.preload", 1'b1, 32'h30, 4'hF, 32'hCAFEF00D, 32'h0);
        okSeen = 0;
        applyStimulus(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h30, 4'hF, 32'hBADBAD00);
        checkOutput("refuse.addrOk", 32'(addrOk), 32'd0);
        okSeen += int'(dataOk);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        for (int c = 0; c < 5; c++) begin
            okSeen += int'(dataOk);
            tick();
        end
        checkOutput("refuse.dataOkCount", 32'(okSeen), 32'd2);
        singleAccess("refuse.load", 1'b0, 32'h30, 4'h0, 32'h0, 32'hCAFEF00D);

        // A store held through a full cycle is accepted exactly once.
        okSeen = 0;
        applyStimulus(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b0, 32'h20, 4'h0, 32'h0);
        tick();
        applyStimulus(1'b1, 1'b1, 32'h30, 4'hF, 32'h12345678);
        checkOutput("held.T2.addrOk", 32'(addrOk), 32'd0);
        okSeen += int'(dataOk);
        tick();
        checkOutput("held.T3.addrOk", 32'(addrOk), 32'd1);
        okSeen += int'(dataOk);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        tick();
        checkOutput("held.T5.dataOk", 32'(dataOk), 32'd1);
        checkOutput("held.T5.rdata", rdata, 32'h0);
        okSeen += int'(dataOk);
        for (int c = 0; c < 4; c++) begin
            tick();
            okSeen += int'(dataOk);
        end
        checkOutput("held.dataOkCount", 32'(okSeen), 32'd3);
        singleAccess("held.load", 1'b0, 32'h30, 4'h0, 32'h0, 32'h12345678);

        // LATENCY=1 continuous stream: three stores, then three loads.
        for (int i = 0; i < 8; i++) begin
            if (i < 6) begin
                req1 = 1'b1; wr1 = streamWr[i]; addr1 = streamAddr[i];
                wstrb1 = 4'hF; wdata1 = streamData[i];
            end else begin
                req1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wstrb1 = 4'h0; wdata1 = 32'h0;
            end
            checkOutput($sformatf("lat1.c%0d.addrOk", i), 32'(addrOk1), 32'd1);
            checkOutput($sformatf("lat1.c%0d.dataOk", i), 32'(dataOk1),
                        (i >= 1 && i <= 6) ? 32'd1 : 32'd0);
            checkOutput($sformatf("lat1.c%0d.rdata", i), rdata1, streamExp[i]);
            tick();
        end

        // Reset one cycle after an accepted load discards that load.
        applyStimulus(1'b1, 1'b0, 32'h10, 4'h0, 32'h0);
        tick();
        applyStimulus(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
        rst = 1'b1;
        #1;
        checkOutput("midrst.addrOk", 32'(addrOk), 32'd1);
        checkOutput("midrst.dataOk", 32'(dataOk), 32'd0);
        checkOutput("midrst.rdata", rdata, 32'h0);
        tick();
        rst = 1'b0;
        checkOutput("midrst.after.addrOk", 32'(addrOk), 32'd1);
        okSeen = 0;
        for (int c = 0; c < 6; c++) begin
            okSeen += int'(dataOk);
            tick();
        end
        checkOutput("midrst.dataOkCount", 32'(okSeen), 32'd0);
        singleAccess("midrst.keep", 1'b0, 32'h20, 4'h0, 32'h0, 32'h11AA3344);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
